mdu_iterative: RTL

- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two read-port operands (rd1_o/rd2_o), the decoded funct3 and the destination register index.
- Over 33 cycles it produces a 32-bit result with write-back controls (wb_reg, wb_en, result) that drive the register file's writeReg/regWrite/writeData.
- The core stalls on busy while an operation is in flight.

---
 rtl/mdu_iterative.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle over 32 cycles, with registered write-back controls.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_reg,
  output logic            wb_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;

  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_s;
  logic [XLEN-1:0]   quo, rem, res_fix;
  logic              div_zero;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && !kill) state_n = S_CALC;
      S_CALC: begin
        if (kill)                                 state_n = S_IDLE;
        else if (cnt == CNT_W'(XLEN - 1))         state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand conditioning at capture: signed operands become magnitudes.
  always_comb begin
    signed_a = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    signed_b = funct3 inside {3'b001, 3'b100, 3'b110};
    neg_a    = signed_a & op_a[XLEN-1];
    neg_b    = signed_b & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
  end

  // acc holds {product_hi, multiplier/product_lo} for multiply and
  // {remainder, dividend/quotient} for divide; opnd is the fixed operand.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (div_diff[XLEN]) div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod_s   = (sign_a ^ sign_b) ? -acc : acc;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    div_zero = (opnd == '0);
    res_fix  = '0;
    case (op_q)
      3'b000:         res_fix = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         res_fix = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: res_fix = div_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
      // With a zero divisor the remainder is the dividend magnitude, so this
      // sign fix-up reproduces the original op_a.
      default:        res_fix = sign_a ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      done   <= 1'b0;
      result <= '0;
      wb_reg <= '0;
      wb_en  <= 1'b0;
    end else begin
      done   <= 1'b0;
      result <= '0;
      wb_reg <= '0;
      wb_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op_q   <= funct3;
            rd_q   <= rd_addr;
            sign_a <= neg_a;
            sign_b <= neg_b;
            acc    <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            opnd   <= funct3[2] ? mag_b : mag_a;
            cnt    <= '0;
          end
        end
        S_CALC: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          done   <= 1'b1;
          result <= res_fix;
          wb_reg <= rd_q;
          wb_en  <= (rd_q != 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
